// File: rtl/core_issue_arbiter.sv
// Round-robin issue arbiter for the shared multi-core execution datapath.
// Registered valid/ready issue slot, DIV/MOD occupancy stall, HLT parking.
module core_issue_arbiter #(
  parameter int unsigned NUM_CORES = 9,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned DIV_LAT   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_CORES-1:0]   req,
  input  logic [8*NUM_CORES-1:0] instr_flat,
  input  logic [8*NUM_CORES-1:0] op1_flat,
  input  logic [8*NUM_CORES-1:0] op2_flat,
  output logic [NUM_CORES-1:0]   gnt,
  input  logic [NUM_CORES-1:0]   resume,
  output logic [NUM_CORES-1:0]   halted,
  output logic                   dp_valid,
  input  logic                   dp_ready,
  output logic [ID_W-1:0]        dp_core_id,
  output logic [7:0]             dp_instruction,
  output logic [7:0]             dp_operand1,
  output logic [7:0]             dp_operand2,
  output logic                   busy
);

  localparam int unsigned PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  localparam logic [7:0] OP_DIV = 8'h04;
  localparam logic [7:0] OP_MOD = 8'h05;
  localparam logic [7:0] OP_HLT = 8'h14;

  logic [0:0]           state, state_nxt;
  logic [CNT_W-1:0]     stall_cnt, stall_cnt_nxt;
  logic [PTR_W-1:0]     ptr, ptr_nxt;
  logic [NUM_CORES-1:0] halted_nxt;
  logic                 dp_valid_nxt;
  logic [ID_W-1:0]      dp_core_id_nxt;
  logic [7:0]           dp_instruction_nxt, dp_operand1_nxt, dp_operand2_nxt;
  logic                 busy_nxt;

  logic [7:0]           instr_a [NUM_CORES];
  logic [7:0]           op1_a   [NUM_CORES];
  logic [7:0]           op2_a   [NUM_CORES];
  logic [NUM_CORES-1:0] eligible;
  logic                 load_ok;
  logic                 consumed;
  logic                 take;
  logic                 win_found;
  logic [PTR_W-1:0]     win_idx;

  // Unpack per-core payload buses.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      instr_a[i] = instr_flat[8*i +: 8];
      op1_a[i]   = op1_flat[8*i +: 8];
      op2_a[i]   = op2_flat[8*i +: 8];
    end
  end

  assign eligible = req & ~halted;
  assign load_ok  = (state == ST_RUN) & (~dp_valid | dp_ready);
  assign consumed = dp_valid & dp_ready;
  assign take     = load_ok & win_found;

  // Rotating priority scan starting at ptr, wrapping modulo NUM_CORES.
  always_comb begin
    logic [PTR_W:0] idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      idx = (PTR_W+1)'(ptr) + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_CORES)) begin
        idx = idx - (PTR_W+1)'(NUM_CORES);
      end
      if (!win_found && eligible[idx[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = idx[PTR_W-1:0];
      end
    end
  end

  // Grant is held low while reset is asserted.
  always_comb begin
    gnt = '0;
    if (reset_n && take) begin
      gnt[win_idx] = 1'b1;
    end
  end

  // Next-state and slot update.
  always_comb begin
    state_nxt          = state;
    stall_cnt_nxt      = stall_cnt;
    ptr_nxt            = ptr;
    halted_nxt         = halted & ~resume;
    dp_valid_nxt       = dp_valid;
    dp_core_id_nxt     = dp_core_id;
    dp_instruction_nxt = dp_instruction;
    dp_operand1_nxt    = dp_operand1;
    dp_operand2_nxt    = dp_operand2;

    case (state)
      ST_RUN: begin
        if (consumed && (dp_instruction == OP_DIV || dp_instruction == OP_MOD)
            && (DIV_LAT > 1)) begin
          state_nxt     = ST_STALL;
          stall_cnt_nxt = CNT_W'(DIV_LAT - 1);
        end
      end
      ST_STALL: begin
        stall_cnt_nxt = stall_cnt - CNT_W'(1);
        if (stall_cnt == CNT_W'(1)) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    if (take) begin
      dp_valid_nxt       = 1'b1;
      dp_core_id_nxt     = ID_W'(win_idx);
      dp_instruction_nxt = instr_a[win_idx];
      dp_operand1_nxt    = op1_a[win_idx];
      dp_operand2_nxt    = op2_a[win_idx];
      ptr_nxt = (win_idx == PTR_W'(NUM_CORES - 1)) ? '0 : win_idx + PTR_W'(1);
      // HLT overrides a coincident resume for the same core.
      if (instr_a[win_idx] == OP_HLT) begin
        halted_nxt[win_idx] = 1'b1;
      end
    end else if (consumed) begin
      dp_valid_nxt = 1'b0;
    end

    busy_nxt = dp_valid_nxt | (state_nxt == ST_STALL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_RUN;
      stall_cnt      <= '0;
      ptr            <= '0;
      halted         <= '0;
      dp_valid       <= 1'b0;
      dp_core_id     <= '0;
      dp_instruction <= '0;
      dp_operand1    <= '0;
      dp_operand2    <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      stall_cnt      <= stall_cnt_nxt;
      ptr            <= ptr_nxt;
      halted         <= halted_nxt;
      dp_valid       <= dp_valid_nxt;
      dp_core_id     <= dp_core_id_nxt;
      dp_instruction <= dp_instruction_nxt;
      dp_operand1    <= dp_operand1_nxt;
      dp_operand2    <= dp_operand2_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_core_issue_arbiter.sv
// Bench for core_issue_arbiter: vector table, directed corner sequences and
// randomized traffic checked against a cycle-level reference model.
module tb_core_issue_arbiter;

  localparam int N       = 9;
  localparam int DIV_LAT = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [8*N-1:0] instr_flat, op1_flat, op2_flat;
  logic [N-1:0]   gnt;
  logic [N-1:0]   resume;
  logic [N-1:0]   halted;
  logic           dp_valid;
  logic           dp_ready;
  logic [3:0]     dp_core_id;
  logic [7:0]     dp_instruction, dp_operand1, dp_operand2;
  logic           busy;

  core_issue_arbiter #(.NUM_CORES(N), .ID_W(4), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .instr_flat(instr_flat),
    .op1_flat(op1_flat), .op2_flat(op2_flat), .gnt(gnt), .resume(resume),
    .halted(halted), .dp_valid(dp_valid), .dp_ready(dp_ready),
    .dp_core_id(dp_core_id), .dp_instruction(dp_instruction),
    .dp_operand1(dp_operand1), .dp_operand2(dp_operand2), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: slot contents, pointer, halted set, remaining stall cycles.
  int m_ptr, m_stall, m_id, m_instr, m_op1, m_op2, m_win;
  bit m_valid, m_found, m_take;
  bit m_halted [N];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_stall = 0; m_valid = 0;
    m_id = 0; m_instr = 0; m_op1 = 0; m_op2 = 0;
    for (int i = 0; i < N; i++) m_halted[i] = 0;
  endtask

  // Settle inputs, predict the cycle, compare every visible output.
  task automatic settle_check();
    logic [N-1:0] exp_gnt, exp_h;
    #2;
    if (!reset_n) model_reset();
    m_found = 0; m_win = 0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (!m_found && req[c] && !m_halted[c]) begin
        m_found = 1; m_win = c;
      end
    end
    m_take = reset_n && (m_stall == 0) && (!m_valid || dp_ready) && m_found;
    exp_gnt = '0;
    if (m_take) exp_gnt[m_win] = 1'b1;
    for (int i = 0; i < N; i++) exp_h[i] = m_halted[i];
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("dp_valid", 32'(dp_valid), 32'(m_valid));
    chk("busy", 32'(busy), 32'(m_valid || m_stall > 0));
    chk("halted", 32'(halted), 32'(exp_h));
    if (m_valid) begin
      chk("dp_core_id", 32'(dp_core_id), 32'(m_id));
      chk("dp_instruction", 32'(dp_instruction), 32'(m_instr));
      chk("dp_operand1", 32'(dp_operand1), 32'(m_op1));
      chk("dp_operand2", 32'(dp_operand2), 32'(m_op2));
    end
  endtask

  // Advance one clock and apply the same transfer rules to the model.
  task automatic edge_upd();
    bit consumed, is_div;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      consumed = m_valid && dp_ready;
      is_div   = (m_instr == 8'h04) || (m_instr == 8'h05);
      if (m_stall > 0) m_stall--;
      else if (consumed && is_div && DIV_LAT > 1) m_stall = DIV_LAT - 1;
      for (int i = 0; i < N; i++) if (resume[i]) m_halted[i] = 0;
      if (m_take) begin
        m_valid = 1; m_id = m_win;
        m_instr = instr_flat[8*m_win +: 8];
        m_op1   = op1_flat[8*m_win +: 8];
        m_op2   = op2_flat[8*m_win +: 8];
        if (m_instr == 8'h14) m_halted[m_win] = 1;
        m_ptr = (m_win + 1) % N;
      end else if (consumed) begin
        m_valid = 0;
      end
    end
    #1;
  endtask

  task automatic step();
    settle_check();
    edge_upd();
  endtask

  task automatic set_core(input int i, input logic [7:0] ins, input logic [7:0] a,
                          input logic [7:0] b);
    instr_flat[8*i +: 8] = ins;
    op1_flat[8*i +: 8]   = a;
    op2_flat[8*i +: 8]   = b;
  endtask

  task automatic do_reset();
    reset_n = 0; req = '0; resume = '0; dp_ready = 0;
    for (int i = 0; i < N; i++) set_core(i, 8'h01, 8'(i), 8'(i + 16));
    step();
    step();
    reset_n = 1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic         ready;
    logic [N-1:0] exp_gnt;
    logic         exp_valid;
    logic [3:0]   exp_id;
  } vec_t;

  vec_t vecs [11];

  initial begin
    bit found;
    vecs[0]  = '{9'h1FF, 1'b1, 9'h001, 1'b0, 4'd0};
    vecs[1]  = '{9'h1FF, 1'b1, 9'h002, 1'b1, 4'd0};
    vecs[2]  = '{9'h1FF, 1'b1, 9'h004, 1'b1, 4'd1};
    vecs[3]  = '{9'h1FF, 1'b1, 9'h008, 1'b1, 4'd2};
    vecs[4]  = '{9'h1FF, 1'b1, 9'h010, 1'b1, 4'd3};
    vecs[5]  = '{9'h1FF, 1'b1, 9'h020, 1'b1, 4'd4};
    vecs[6]  = '{9'h1FF, 1'b1, 9'h040, 1'b1, 4'd5};
    vecs[7]  = '{9'h1FF, 1'b1, 9'h080, 1'b1, 4'd6};
    vecs[8]  = '{9'h1FF, 1'b1, 9'h100, 1'b1, 4'd7};
    vecs[9]  = '{9'h1FF, 1'b1, 9'h001, 1'b1, 4'd8};
    vecs[10] = '{9'h1FF, 1'b1, 9'h002, 1'b1, 4'd0};

    model_reset();
    do_reset();

    // Reset during a stall with a held slot.
    set_core(2, 8'h04, 8'd9, 8'd3);
    req = 9'h004; dp_ready = 1;
    step();
    set_core(3, 8'h01, 8'd7, 8'd8);
    req = 9'h008;
    step();
    dp_ready = 0; req = 9'h1FF;
    settle_check();
    chk("pre_reset_valid", 32'(dp_valid), 32'd1);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    chk("pre_reset_gnt", 32'(gnt), 32'd0);
    reset_n = 0;
    #1;
    chk("rst_dp_valid", 32'(dp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_payload", {8'(dp_core_id), dp_instruction, dp_operand1, dp_operand2}, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    edge_upd();
    step();
    reset_n = 1;
    for (int i = 0; i < N; i++) set_core(i, 8'h01, 8'(i), 8'(i + 16));

    // Round-robin vector table straight out of reset.
    for (int v = 0; v < 11; v++) begin
      req = vecs[v].req; dp_ready = vecs[v].ready;
      settle_check();
      chk("tbl_gnt", 32'(gnt), 32'(vecs[v].exp_gnt));
      chk("tbl_valid", 32'(dp_valid), 32'(vecs[v].exp_valid));
      if (vecs[v].exp_valid) chk("tbl_id", 32'(dp_core_id), 32'(vecs[v].exp_id));
      edge_upd();
    end

    // Backpressure: slot held stable, no grant.
    do_reset();
    set_core(3, 8'h01, 8'h01, 8'h02);
    req = 9'h008; dp_ready = 0;
    step();
    req = 9'h010;
    repeat (5) begin
      settle_check();
      chk("bp_gnt", 32'(gnt), 32'd0);
      chk("bp_id", 32'(dp_core_id), 32'd3);
      chk("bp_ops", {16'd0, dp_operand1, dp_operand2}, 32'h0102);
      edge_upd();
    end
    dp_ready = 1;
    settle_check();
    chk("bp_release_gnt", 32'(gnt), 32'h010);
    edge_upd();
    req = 9'h000;
    settle_check();
    chk("bp_next_id", 32'(dp_core_id), 32'd4);
    edge_upd();

    // DIV stall timing.
    do_reset();
    set_core(2, 8'h04, 8'd20, 8'd5);
    req = 9'h004; dp_ready = 1;
    step();
    req = 9'h000;
    settle_check();
    chk("div_in_slot", 32'(dp_instruction), 32'h04);
    edge_upd();
    req = 9'h001;
    repeat (3) begin
      settle_check();
      chk("div_stall_gnt", 32'(gnt), 32'd0);
      chk("div_stall_busy", 32'(busy), 32'd1);
      edge_upd();
    end
    settle_check();
    chk("div_resume_gnt", 32'(gnt), 32'h001);
    edge_upd();
    req = 9'h000;
    settle_check();
    chk("div_next_id", 32'(dp_core_id), 32'd0);
    chk("div_next_valid", 32'(dp_valid), 32'd1);
    edge_upd();

    // HLT parking, resume, and HLT-beats-resume.
    do_reset();
    set_core(5, 8'h14, 8'd0, 8'd0);
    req = 9'h020; dp_ready = 1;
    step();
    set_core(5, 8'h01, 8'd1, 8'd1);
    req = 9'h060;
    repeat (4) begin
      settle_check();
      chk("hlt_halted5", 32'(halted[5]), 32'd1);
      chk("hlt_skip_gnt", 32'(gnt), 32'h040);
      edge_upd();
    end
    resume = 9'h020;
    step();
    resume = 9'h000;
    found = 0;
    for (int c = 0; c < N && !found; c++) begin
      settle_check();
      if (gnt[5]) found = 1;
      edge_upd();
    end
    chk("hlt_regrant_within_9", 32'(found), 32'd1);
    set_core(5, 8'h14, 8'd0, 8'd0);
    req = 9'h020; resume = 9'h020;
    settle_check();
    chk("hlt_coincident_gnt", 32'(gnt), 32'h020);
    edge_upd();
    resume = 9'h000; req = 9'h000;
    settle_check();
    chk("hlt_wins_resume", 32'(halted[5]), 32'd1);
    edge_upd();

    // Pointer wrap and a single requester.
    do_reset();
    req = 9'h080; dp_ready = 1;
    step();
    req = 9'h102;
    settle_check();
    chk("wrap_gnt8", 32'(gnt), 32'h100);
    edge_upd();
    settle_check();
    chk("wrap_gnt1", 32'(gnt), 32'h002);
    edge_upd();
    req = 9'h010;
    repeat (3) begin
      settle_check();
      chk("single_gnt4", 32'(gnt), 32'h010);
      edge_upd();
    end

    // Randomized traffic against the model.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      req = N'($urandom);
      dp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        int r;
        resume[i] = ($urandom_range(0, 7) == 0);
        r = $urandom_range(0, 9);
        set_core(i, (r == 0) ? 8'h04 : (r == 1) ? 8'h05 : (r == 2) ? 8'h14 : 8'($urandom),
                 8'($urandom), 8'($urandom));
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
